mor1kx_rf_banked: RTL
=====================

Name: mor1kx_rf_banked

Overview:
- Parametrised successor to the cappuccino GPR file.
- N registered read ports; optional shadow register contexts (fast-context banks); ctrl-stage and write-back bypass on every read port.
- Sequential post-reset clear engine; SPR access to any context, with write-port arbitration.
- Sits between decode (read ports) and write-back (write port) in the cappuccino pipeline.

Parameters:
OPTION_OPERAND_WIDTH, 32, data width W
OPTION_RF_ADDR_WIDTH, 5, register index width A (2^A registers per context)
NUM_READ_PORTS, 2, independent read ports P (1..4)
NUM_CONTEXTS, 1, register banks C (power of 2, 1..16; C*2^A <= 512)
OPTION_RF_CLEAR_ON_INIT, 1, 1 = zero all storage after reset via sweep FSM

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ctx_sel_i  in  max(1,log2 C)  active context for read, write and bypass ports
rd_en_i  in  P  per-port read enable
rd_adr_i  in  P*A  per-port register index; port k at [k*A +: A]
rd_dat_o  out  P*W  per-port registered read data
wb_we_i  in  1  write-back write enable
wb_adr_i  in  A  write-back register index
wb_dat_i  in  W  write-back data
ctrl_byp_valid_i  in  1  ctrl-stage result pending write
ctrl_byp_adr_i  in  A  ctrl-stage destination index
ctrl_byp_dat_i  in  W  ctrl-stage result
spr_stb_i  in  1  SPR strobe
spr_we_i  in  1  SPR write
spr_adr_i  in  16  SPR address
spr_dat_i  in  W  SPR write data
spr_ack_o  out  1  SPR ack, one-cycle pulse
spr_dat_o  out  W  SPR read data, valid with ack
init_busy_o  out  1  clear sweep in progress

Behaviour:
- Storage: C*2^A words. Physical index = {ctx, adr}. r0 is not hardwired.
- Async reset: rd_dat_o=0, spr_ack_o=0, spr_dat_o=0. FSM enters CLEAR if OPTION_RF_CLEAR_ON_INIT=1, else RUN. init_busy_o = (state==CLEAR).
- FSM CLEAR:
  - Counter starts at 0 on the first clk after rst_n rises.
  - Writes 0 to word[counter] each cycle.
  - Exits to RUN after writing word C*2^A-1, so init_busy_o is high exactly C*2^A cycles.
  - Read ports return 0 (rd_dat_o updates with 0 when rd_en). wb writes dropped. SPR strobes are not acked; the SPR master holds stb until ack.
- FSM RUN: no exit except reset. Async reset mid-sweep restarts the counter at 0.
- Read, latency 1:
  - On a clk edge with rd_en_i[k]=1, rd_dat_o[k] loads, in priority order:
    1. ctrl_byp_dat_i if ctrl_byp_valid_i and ctrl_byp_adr_i==rd_adr[k].
    2. Else wb_dat_i if wb_we_i and wb_adr_i==rd_adr[k] (same-cycle write forwarded).
    3. Else word[{ctx_sel_i, rd_adr[k]}].
  - Bypass compares only within the current ctx_sel_i.
  - rd_en_i[k]=0: rd_dat_o[k] holds.
  - All ports are independent; identical addresses on multiple ports are legal.
- Write: wb_we_i writes word[{ctx_sel_i, wb_adr_i}] at the clk edge. The ctrl bypass never writes storage.
- SPR decode:
  - Hit = spr_stb_i and spr_adr_i[15:9]==7'b0000010 and ctx field < C.
  - ctx field = spr_adr_i[8:A]; reg = spr_adr_i[A-1:0].
  - GPR0 of context 0 is at 0x400; context n is at 0x400 + n*2^A.
  - Non-hit: no ack, no action.
- SPR read: on a hit with !spr_we_i in RUN, spr_ack_o=1 next cycle and spr_dat_o=word[{ctx,reg}]. Bypass is not applied.
- SPR write:
  - On a hit with spr_we_i in RUN and no wb_we_i that cycle: write, then ack next cycle.
  - If wb_we_i is high the same cycle: wb wins, and the SPR write retries each cycle until the write port is free.
- Ack pulse: ack is one cycle. The cycle after ack, the hit is masked (no double ack) even if stb is still high. spr_dat_o holds its last value otherwise.

Test Plan:
1. C=2, A=5, clear on: release reset → init_busy_o high exactly 64 cycles. Then a read of all 32 regs in both contexts returns 0.
2. wb write r3=0xDEADBEEF with rd_en port0 adr 3 in the same cycle → rd_dat_o[0]=0xDEADBEEF next cycle. The next read of r3 without wb also returns 0xDEADBEEF.
3. ctrl_byp r3=0x11111111 and wb r3=0x22222222 in the same cycle, ports 0 and 1 both read r3 → both return 0x11111111. A subsequent read returns 0x22222222.
4. ctx_sel=0 writes r5=0xA5; SPR write 0x425=0x5A (ctx 1 r5). SPR read 0x405 → ack after 1 cycle with data 0xA5. SPR read 0x425 → 0x5A. Read r5 with ctx_sel=1 → 0x5A.
5. SPR write 0x407 while wb_we_i is high for 2 cycles → ack on the 3rd cycle and r7 holds the SPR value. SPR address 0x440 with C=2 → never acks.
6. Assert rst_n low at sweep cycle 20, release → sweep restarts and runs the full 64 cycles. An SPR strobe issued during the sweep acks only after init_busy_o falls.

Source files
------------

// File: rtl/mor1kx_rf_banked.sv
// Banked general-purpose register file for the cappuccino pipeline.
// N registered read ports with ctrl-stage and write-back bypass, optional
// shadow contexts, a post-reset clear sweep, and SPR access to any context
// sharing the single write port (write-back has priority).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | sweeping zeros through every word, reads return 0, no SPR
// S_RUN   | normal operation until the next reset
module mor1kx_rf_banked #(
  parameter int OPTION_OPERAND_WIDTH    = 32,
  parameter int OPTION_RF_ADDR_WIDTH    = 5,
  parameter int NUM_READ_PORTS          = 2,
  parameter int NUM_CONTEXTS            = 1,
  parameter int OPTION_RF_CLEAR_ON_INIT = 1,
  localparam int CTX_W = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [CTX_W-1:0]                               ctx_sel_i,
  input  logic [NUM_READ_PORTS-1:0]                      rd_en_i,
  input  logic [NUM_READ_PORTS*OPTION_RF_ADDR_WIDTH-1:0] rd_adr_i,
  output logic [NUM_READ_PORTS*OPTION_OPERAND_WIDTH-1:0] rd_dat_o,
  input  logic                                           wb_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]                wb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                wb_dat_i,
  input  logic                                           ctrl_byp_valid_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]                ctrl_byp_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                ctrl_byp_dat_i,
  input  logic                                           spr_stb_i,
  input  logic                                           spr_we_i,
  input  logic [15:0]                                    spr_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                spr_dat_i,
  output logic                                           spr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]                spr_dat_o,
  output logic                                           init_busy_o
);

  localparam int W     = OPTION_OPERAND_WIDTH;
  localparam int A     = OPTION_RF_ADDR_WIDTH;
  localparam int P     = NUM_READ_PORTS;
  localparam int CB    = $clog2(NUM_CONTEXTS);
  localparam int IW    = CB + A;
  localparam int DEPTH = 1 << IW;

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic            clearing;
  logic [IW-1:0]   clr_cnt;
  logic [W-1:0]    mem [DEPTH];
  logic [IW-1:0]   ctx_base;

  logic            mem_we;
  logic [IW-1:0]   mem_wa;
  logic [W-1:0]    mem_wd;

  logic            spr_hit, spr_rd_go, spr_wr_go;
  logic [IW-1:0]   spr_idx;
  logic            spr_ctx_ok;

  // Physical index is {ctx, adr}; with a single context the ctx select is ignored.
  if (CB == 0) begin : g_one_ctx
    logic ctx_unused;
    assign ctx_unused = ^ctx_sel_i;
    assign ctx_base   = '0;
  end else begin : g_multi_ctx
    assign ctx_base = {ctx_sel_i[CB-1:0], {A{1'b0}}};
  end

  // State register: the sweep restarts from word 0 after every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= (OPTION_RF_CLEAR_ON_INIT != 0) ? S_CLEAR : S_RUN;
    else        state <= state_nxt;
  end

  // Next state: leave the sweep once the last word has been written.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (&clr_cnt) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    clearing = (state == S_CLEAR);
  end

  assign init_busy_o = clearing;

  // Sweep pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        clr_cnt <= '0;
    else if (clearing) clr_cnt <= clr_cnt + IW'(1);
  end

  // SPR window 0x400..0x5FF; the context field above the register index must be < C.
  assign spr_ctx_ok = ((spr_adr_i[8:0] >> IW) == 9'd0);
  assign spr_idx    = spr_adr_i[IW-1:0];
  assign spr_hit    = spr_stb_i && (spr_adr_i[15:9] == 7'b0000010) && spr_ctx_ok &&
                      !spr_ack_o && !clearing;
  assign spr_rd_go  = spr_hit && !spr_we_i;
  assign spr_wr_go  = spr_hit && spr_we_i && !wb_we_i;

  // Single write port: sweep, then write-back, then SPR write.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (clearing) begin
      mem_we = 1'b1;
      mem_wa = clr_cnt;
    end else if (wb_we_i) begin
      mem_we = 1'b1;
      mem_wa = ctx_base | IW'(wb_adr_i);
      mem_wd = wb_dat_i;
    end else if (spr_wr_go) begin
      mem_we = 1'b1;
      mem_wa = spr_idx;
      mem_wd = spr_dat_i;
    end
  end

  // Storage array, no reset (the sweep provides the clean start).
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // SPR response: one-cycle ack, read data captured only on reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spr_ack_o <= 1'b0;
      spr_dat_o <= '0;
    end else begin
      spr_ack_o <= spr_rd_go || spr_wr_go;
      if (spr_rd_go) spr_dat_o <= mem[spr_idx];
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_rd
    logic [A-1:0]  adr;
    logic [IW-1:0] idx;
    logic [W-1:0]  rd_q;

    assign adr = rd_adr_i[k*A +: A];
    assign idx = ctx_base | IW'(adr);

    // Registered read with ctrl bypass over write-back bypass over storage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else if (rd_en_i[k]) begin
        if (clearing)                                        rd_q <= '0;
        else if (ctrl_byp_valid_i && ctrl_byp_adr_i == adr)  rd_q <= ctrl_byp_dat_i;
        else if (wb_we_i && wb_adr_i == adr)                 rd_q <= wb_dat_i;
        else                                                 rd_q <= mem[idx];
      end
    end

    assign rd_dat_o[k*W +: W] = rd_q;
  end

endmodule
